// File: rtl/mem_copy_initiator_pkg.sv
// Shared constants and state encodings for the byte copy initiator.
// Widths, lane indices and the top/read/write lane state values.
package mem_copy_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 4;

  localparam int unsigned LANE_RD = 0;
  localparam int unsigned LANE_WR = 1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = SIZE_W'(DATA_W);

  typedef logic [1:0] top_state_t;
  localparam top_state_t T_IDLE = 2'd0;
  localparam top_state_t T_RUN  = 2'd1;
  localparam top_state_t T_DONE = 2'd2;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_REQ  = 2'd1;
  localparam rd_state_t R_GAP  = 2'd2;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_REQ  = 2'd1;
  localparam wr_state_t W_GAP  = 2'd2;

endpackage

// File: rtl/mem_copy_initiator_if.sv
// Two-lane minimal memory bus: per-lane oe/we, packed addr/Wdata/size,
// returned Rdata and per-lane DataRdy. master = initiator side.
interface mem_copy_initiator_if;
  import mem_copy_pkg::*;

  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [2*DATA_W-1:0] Mout_Wdata_ram;
  logic [2*SIZE_W-1:0] Mout_data_ram_size;
  logic [2*DATA_W-1:0] M_Rdata_ram;
  logic [1:0]          M_DataRdy;

  modport master (
    output Mout_oe_ram,
    output Mout_we_ram,
    output Mout_addr_ram,
    output Mout_Wdata_ram,
    output Mout_data_ram_size,
    input  M_Rdata_ram,
    input  M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram,
    input  Mout_we_ram,
    input  Mout_addr_ram,
    input  Mout_Wdata_ram,
    input  Mout_data_ram_size,
    output M_Rdata_ram,
    output M_DataRdy
  );

endinterface

// File: rtl/mem_copy_initiator_byte_fifo2.sv
// Two-entry byte FIFO between the read lane and the write lane.
// Ports: clock, reset, push/din, pop, full, empty, head.
module byte_fifo2
  import mem_copy_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [2];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign head  = mem[rp];

  a_no_push_full: assert property (
    @(posedge clock) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (
    @(posedge clock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/mem_copy_initiator.sv
// Copies len bytes src->dst; lane 0 reads, lane 1 writes, via 2-byte FIFO.
// Ports: clock, reset, start_port/src/dst/len, busy, done_port, mem bus.
module mem_copy_initiator
  import mem_copy_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_port,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done_port,
  mem_copy_initiator_if.master mem
);

  top_state_t        top_q;
  rd_state_t         rd_q;
  wr_state_t         wr_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt;
  logic [LEN_W-1:0]  wr_cnt;

  logic              rd_req;
  logic              wr_req;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              rd_go;
  logic              wr_go;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign rd_req = (rd_q == R_REQ);
  assign wr_req = (wr_q == W_REQ);
  assign push   = rd_req & mem.M_DataRdy[LANE_RD];
  assign pop    = wr_req & mem.M_DataRdy[LANE_WR];

  // Only one read is ever outstanding, so "not full" here
  // guarantees room for its byte when it completes.
  assign rd_go = (top_q == T_RUN) && (rd_cnt < len_q) && !full;
  assign wr_go = !empty;

  assign rd_addr = src_q + ADDR_W'(rd_cnt);
  assign wr_addr = dst_q + ADDR_W'(wr_cnt);

  byte_fifo2 u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (mem.M_Rdata_ram[DATA_W-1:0]),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      top_q  <= T_IDLE;
      rd_q   <= R_IDLE;
      wr_q   <= W_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      unique case (top_q)
        T_IDLE: begin
          if (start_port) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len;
            rd_cnt <= '0;
            wr_cnt <= '0;
            top_q  <= (len == '0) ? T_DONE : T_RUN;
          end
        end
        T_RUN:   if (wr_cnt == len_q) top_q <= T_DONE;
        default: top_q <= T_IDLE;
      endcase

      unique case (rd_q)
        R_IDLE: if (rd_go) rd_q <= R_REQ;
        R_REQ: begin
          if (push) begin
            rd_cnt <= rd_cnt + LEN_W'(1);
            rd_q   <= R_GAP;
          end
        end
        default: rd_q <= R_IDLE;
      endcase

      unique case (wr_q)
        W_IDLE: if (wr_go) wr_q <= W_REQ;
        W_REQ: begin
          if (pop) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
            wr_q   <= W_GAP;
          end
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  assign busy      = (top_q == T_RUN);
  assign done_port = (top_q == T_DONE);

  assign mem.Mout_oe_ram    = {1'b0, rd_req};
  assign mem.Mout_we_ram    = {wr_req, 1'b0};
  assign mem.Mout_addr_ram  = {wr_req ? wr_addr : '0,
                               rd_req ? rd_addr : '0};
  assign mem.Mout_Wdata_ram = {wr_req ? head : '0,
                               {DATA_W{1'b0}}};
  assign mem.Mout_data_ram_size = {wr_req ? SIZE_BYTE : '0,
                                   rd_req ? SIZE_BYTE : '0};

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench: memory responder, transaction-level model, checks.
// Summary: CHECKS <n> ERRORS <n>.
module tb_mem_copy_initiator;
  import mem_copy_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_port = 1'b0;
  logic [6:0] src_addr = '0;
  logic [6:0] dst_addr = '0;
  logic [7:0] len = '0;
  logic       busy;
  logic       done_port;

  mem_copy_initiator_if mif ();

  mem_copy_initiator dut (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_port),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done_port  (done_port),
    .mem        (mif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory and responder settings
  logic [7:0] mem_arr [0:127];
  int rd_delay = 2;
  int wr_delay = 1;
  int wr_stall = 0;
  int rcnt = 0;
  int wcnt = 0;

  // Transaction model of the current transfer
  logic [6:0] x_src, x_dst;
  int         x_len = 0;
  logic [7:0] snap [0:255];
  int rd_starts = 0, wr_starts = 0;
  int rd_done = 0, wr_done = 0;
  int done_cnt = 0, max_occ = 0;
  logic [7:0] rd_bytes [$];
  logic [6:0] rd_log [$];
  logic [6:0] wr_log [$];

  logic [1:0]  oe, we;
  logic [6:0]  a0, a1, prev_a0, prev_a1;
  logic [15:0] wd, prev_wd;
  logic [7:0]  sz;
  logic        r0, r1, prev_oe, prev_we;

  always @(negedge clock) begin
    r0 = mif.M_DataRdy[0];
    r1 = mif.M_DataRdy[1];
    if (reset) begin
      mif.M_DataRdy = 2'b00;
      rcnt = 0;
      wcnt = 0;
      prev_oe = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (r0) rd_done++;
      if (r1) wr_done++;
      oe = mif.Mout_oe_ram;
      we = mif.Mout_we_ram;
      a0 = mif.Mout_addr_ram[6:0];
      a1 = mif.Mout_addr_ram[13:7];
      wd = mif.Mout_Wdata_ram;
      sz = mif.Mout_data_ram_size;
      chk("lane1_oe", {31'd0, oe[1]}, 0);
      chk("lane0_we", {31'd0, we[0]}, 0);
      if (r0) chk("rd_gap", {31'd0, oe[0]}, 0);
      if (r1) chk("wr_gap", {31'd0, we[1]}, 0);
      if (rd_done - wr_done > max_occ) max_occ = rd_done - wr_done;
      if (rd_done - wr_done >= 2) chk("full_no_oe", {31'd0, oe[0]}, 0);
      chk("occ_le2", 32'(rd_done - wr_done <= 2), 1);
      if (oe[0]) begin
        if (!prev_oe) begin
          chk("rd_addr", {25'd0, a0}, {25'd0, 7'(x_src + rd_starts)});
          chk("rd_count", 32'(rd_starts < x_len), 1);
          rd_log.push_back(a0);
          rd_starts++;
        end else begin
          chk("rd_hold", {25'd0, a0}, {25'd0, prev_a0});
        end
      end
      chk("size0", {28'd0, sz[3:0]}, oe[0] ? 32'd8 : 32'd0);
      chk("size1", {28'd0, sz[7:4]}, we[1] ? 32'd8 : 32'd0);
      chk("wdata_lo", {24'd0, wd[7:0]}, 0);
      if (we[1]) begin
        if (!prev_we) begin
          chk("wr_addr", {25'd0, a1}, {25'd0, 7'(x_dst + wr_starts)});
          chk("wr_count", 32'(wr_starts < x_len), 1);
          chk("wr_has_rd", 32'(wr_starts < rd_bytes.size()), 1);
          if (wr_starts < rd_bytes.size())
            chk("wr_data", {24'd0, wd[15:8]},
                {24'd0, rd_bytes[wr_starts]});
          wr_log.push_back(a1);
          wr_starts++;
        end else begin
          chk("wr_hold", {9'd0, a1, wd}, {9'd0, prev_a1, prev_wd});
        end
      end
      if (done_port) begin
        done_cnt++;
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_writes", wr_done, x_len);
      end
      // Responder: strobes for the next rising edge
      mif.M_DataRdy = 2'b00;
      mif.M_Rdata_ram = 16'($urandom);
      if (oe[0] && !r0) begin
        rcnt++;
        if (rcnt >= rd_delay) begin
          mif.M_DataRdy[0] = 1'b1;
          mif.M_Rdata_ram = {8'h00, mem_arr[a0]};
          rd_bytes.push_back(mem_arr[a0]);
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
      if (we[1] && !r1) begin
        if (wr_stall > 0) begin
          wr_stall--;
        end else begin
          wcnt++;
          if (wcnt >= wr_delay) begin
            mif.M_DataRdy[1] = 1'b1;
            mem_arr[a1] = wd[15:8];
            wcnt = 0;
          end
        end
      end else begin
        wcnt = 0;
      end
      prev_oe = oe[0];
      prev_we = we[1];
      prev_a0 = a0;
      prev_a1 = a1;
      prev_wd = wd;
    end
  end

  task automatic start_xfer(input logic [6:0] s, input logic [6:0] d,
                            input logic [7:0] l);
    @(posedge clock); #1;
    x_src = s;
    x_dst = d;
    x_len = int'(l);
    rd_starts = 0;
    wr_starts = 0;
    rd_done = 0;
    wr_done = 0;
    done_cnt = 0;
    max_occ = 0;
    rd_bytes.delete();
    rd_log.delete();
    wr_log.delete();
    for (int i = 0; i < int'(l); i++) snap[i] = mem_arr[7'(s + i)];
    src_addr = s;
    dst_addr = d;
    len = l;
    start_port = 1'b1;
    @(posedge clock); #1;
    start_port = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      @(posedge clock);
      n++;
    end
    chk(name, 32'(done_cnt > 0), 1);
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic check_copy(input string name);
    for (int i = 0; i < x_len; i++)
      chk(name, {24'd0, mem_arr[7'(x_dst + i)]}, {24'd0, snap[i]});
  endtask

  task automatic check_idle_outputs(input string name);
    chk(name, {mif.Mout_oe_ram, mif.Mout_we_ram,
               mif.Mout_data_ram_size, 20'd0}, 0);
    chk(name, {2'd0, mif.Mout_addr_ram, mif.Mout_Wdata_ram}, 0);
    chk(name, {30'd0, busy, done_port}, 0);
  endtask

  logic [6:0] exp_rd [4];
  logic [6:0] exp_wr [4];
  logic [7:0] exp_b  [4];

  initial begin
    exp_rd = '{7'h7E, 7'h7F, 7'h00, 7'h01};
    exp_wr = '{7'h7F, 7'h00, 7'h01, 7'h02};
    exp_b  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 128; i++) mem_arr[i] = 8'(i * 3 + 1);
    for (int i = 0; i < 4; i++) mem_arr[16 + i] = exp_b[i];

    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset_state");
    reset = 1'b0;

    // Basic copy
    start_xfer(7'h10, 7'h40, 8'd4);
    wait_done("basic_timeout", 100);
    for (int i = 0; i < 4; i++)
      chk("basic_mem", {24'd0, mem_arr[7'h40 + i]}, {24'd0, exp_b[i]});
    chk("basic_reads", rd_starts, 4);
    chk("basic_writes", wr_starts, 4);
    chk("basic_done", done_cnt, 1);

    // Zero length
    start_xfer(7'h10, 7'h50, 8'd0);
    chk("zl_done", {31'd0, done_port}, 1);
    chk("zl_busy", {31'd0, busy}, 0);
    @(posedge clock); #1;
    chk("zl_done_off", {31'd0, done_port}, 0);
    chk("zl_busy2", {31'd0, busy}, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("zl_accesses", rd_starts + wr_starts, 0);
    chk("zl_done_cnt", done_cnt, 1);

    // Write backpressure
    wr_stall = 20;
    start_xfer(7'h20, 7'h58, 8'd6);
    wait_done("bp_timeout", 300);
    chk("bp_max_occ", max_occ, 2);
    chk("bp_reads", rd_starts, 6);
    chk("bp_writes", wr_starts, 6);
    check_copy("bp_mem");

    // Address wrap
    start_xfer(7'h7E, 7'h7F, 8'd4);
    wait_done("wrap_timeout", 100);
    chk("wrap_nrd", rd_log.size(), 4);
    chk("wrap_nwr", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_log.size())
        chk("wrap_rd", {25'd0, rd_log[i]}, {25'd0, exp_rd[i]});
      if (i < wr_log.size())
        chk("wrap_wr", {25'd0, wr_log[i]}, {25'd0, exp_wr[i]});
    end

    // Reset mid-transfer
    start_xfer(7'h30, 7'h60, 8'd8);
    begin
      int n = 0;
      while (wr_done < 2 && n < 200) begin
        @(posedge clock);
        n++;
      end
    end
    chk("rst_progress", 32'(wr_done >= 2), 1);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle_outputs("rst_outputs");
    repeat (10) @(posedge clock);
    #1;
    chk("rst_no_done", done_cnt, 0);
    start_xfer(7'h30, 7'h68, 8'd3);
    wait_done("rst_timeout", 100);
    chk("rst_reads", rd_starts, 3);
    chk("rst_writes", wr_starts, 3);
    check_copy("rst_mem");

    // Start while busy
    start_xfer(7'h10, 7'h48, 8'd4);
    repeat (4) @(posedge clock);
    #1;
    chk("sb_busy", {31'd0, busy}, 1);
    src_addr = 7'h00;
    dst_addr = 7'h00;
    len = 8'd9;
    start_port = 1'b1;
    @(posedge clock); #1;
    start_port = 1'b0;
    wait_done("sb_timeout", 100);
    chk("sb_reads", rd_starts, 4);
    chk("sb_writes", wr_starts, 4);
    chk("sb_done", done_cnt, 1);
    chk("sb_idle", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++)
      chk("sb_mem", {24'd0, mem_arr[7'h48 + i]}, {24'd0, exp_b[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
